// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller side uses the master modport; the datapath side uses slave.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Datapath strobes decode from the state register; PCWrite also folds in the ALU Zero flag.
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Only add/sub, slt, or and and are implemented for R- and I-type.
  function automatic logic alu_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b110:  ok = 1'b1;
      3'b111:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate-type ALUs never subtract: op[5] is clear for I-type, so addi stays add.
  function automatic logic [2:0] funct_alu_ctl(input logic [2:0] f3, input logic op5,
                                               input logic f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
      3'b010:  ctl = 3'b101;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  function automatic logic [1:0] imm_src_of(input logic [6:0] opc);
    logic [1:0] imm;
    case (opc)
      OP_LW:   imm = 2'b00;
      OP_I:    imm = 2'b00;
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    return imm;
  endfunction

  state_e     state_q;
  state_e     state_d;

  logic       pc_update_s;
  logic       branch_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       reg_write_s;
  logic [1:0] alu_op_s;
  logic [2:0] alu_ctl_s;
  logic       illegal_s;

  // State register; reset lands in IDLE, which asserts nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW:   state_d = S_MEMADR;
          OP_SW:   state_d = S_MEMADR;
          OP_R:    state_d = alu_f3_legal(bus.funct3) ? S_EXECR : S_ILLEGAL;
          OP_I:    state_d = alu_f3_legal(bus.funct3) ? S_EXECI : S_ILLEGAL;
          OP_JAL:  state_d = S_JAL;
          OP_BEQ:  state_d = S_BEQ;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL: begin
        if (ILLEGAL_HALT) begin
          state_d = S_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; anything not named in a state stays at zero.
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    reg_write_s  = 1'b0;
    alu_op_s     = ALUOP_ADD;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_update_s  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALUOP_SUB;
        branch_s    = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // ALU operation select from the abstract ALU op.
  always_comb begin
    alu_ctl_s = 3'b000;
    case (alu_op_s)
      ALUOP_ADD:   alu_ctl_s = 3'b000;
      ALUOP_SUB:   alu_ctl_s = 3'b001;
      ALUOP_FUNCT: alu_ctl_s = funct_alu_ctl(bus.funct3, bus.op[5], bus.funct7b5);
      default:     alu_ctl_s = 3'b000;
    endcase
  end

  // Branch resolution happens in the BEQ cycle itself, hence the combinational Zero term.
  assign bus.PCWrite    = pc_update_s | (branch_s & bus.Zero);
  assign bus.AdrSrc     = adr_src_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ImmSrc     = imm_src_of(bus.op);
  assign bus.RegWrite   = reg_write_s;
  assign bus.ALUControl = alu_ctl_s;
  assign bus.illegal    = illegal_s;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instruction streams checked against
// a per-instruction phase plan; a second instance covers the non-halting ILLEGAL option.
module tb_multicycle_controller;
  logic clk;
  logic rst_n;

  multicycle_controller_if if0 ();
  multicycle_controller_if if1 ();

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

  int total = 0;
  int bad = 0;
  int plan_q[$];
  logic [6:0] op;
  logic [2:0] f3;
  logic f7, zero;

  assign if0.op = op;  assign if0.funct3 = f3;  assign if0.funct7b5 = f7;  assign if0.Zero = zero;
  assign if1.op = op;  assign if1.funct3 = f3;  assign if1.funct7b5 = f7;  assign if1.Zero = zero;

  wire [20:0] vec0 = {if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.ResultSrc,
                      if0.ALUSrcA, if0.ALUSrcB, if0.ImmSrc, if0.RegWrite, if0.ALUControl,
                      if0.illegal, if0.state_dbg};
  wire [20:0] vec1 = {if1.PCWrite, if1.AdrSrc, if1.MemWrite, if1.IRWrite, if1.ResultSrc,
                      if1.ALUSrcA, if1.ALUSrcB, if1.ImmSrc, if1.RegWrite, if1.ALUControl,
                      if1.illegal, if1.state_dbg};

  // Expected output vector for a phase (numbered as state_dbg) and the current instruction.
  function automatic logic [20:0] exp_vec(input int st, input logic [6:0] o, input logic [2:0] fn3,
                                          input logic fb, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alc, fa;
    logic [3:0] sn;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; alc = 3'd0;
    sn = st[3:0];
    if (fn3 == 3'b000)      fa = (o == RT && fb) ? 3'b001 : 3'b000;
    else if (fn3 == 3'b010) fa = 3'b101;
    else if (fn3 == 3'b110) fa = 3'b011;
    else                    fa = 3'b010;
    if (o == SW)       imm = 2'd1;
    else if (o == BEQ) imm = 2'd2;
    else if (o == JAL) imm = 2'd3;
    else               imm = 2'd0;
    case (st)
      1:  begin irw = 1'b1; sb = 2'd2; rs = 2'd2; pcw = 1'b1; end
      2:  begin sa = 2'd1; sb = 2'd1; end
      3:  begin sa = 2'd2; sb = 2'd1; end
      4:  adr = 1'b1;
      5:  begin rs = 2'd1; rw = 1'b1; end
      6:  begin adr = 1'b1; mw = 1'b1; end
      7:  begin sa = 2'd2; alc = fa; end
      8:  begin sa = 2'd2; sb = 2'd1; alc = fa; end
      9:  rw = 1'b1;
      10: begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
      11: begin sa = 2'd2; alc = 3'b001; pcw = z; end
      12: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alc, ill, sn};
  endfunction

  // Phase sequence an instruction walks through, from its class alone.
  function automatic void make_plan(input logic [6:0] o, input logic [2:0] fn3);
    logic ok;
    ok = (fn3 == 3'b000) || (fn3 == 3'b010) || (fn3 == 3'b110) || (fn3 == 3'b111);
    plan_q.delete();
    if (o == LW)                 plan_q = '{1, 2, 3, 4, 5};
    else if (o == SW)            plan_q = '{1, 2, 3, 6};
    else if (o == RT && ok)      plan_q = '{1, 2, 7, 9};
    else if (o == IT && ok)      plan_q = '{1, 2, 8, 9};
    else if (o == JAL)           plan_q = '{1, 2, 10, 9};
    else if (o == BEQ)           plan_q = '{1, 2, 11};
    else                         plan_q = '{1, 2, 12};
  endfunction

  task automatic chk(input string tag, input int which, input logic [20:0] exp);
    logic [20:0] got;
    got = (which == 0) ? vec0 : vec1;
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s dut%0d got=%h exp=%h t=%0t", tag, which, got, exp, $time);
    end
  endtask

  // Runs one instruction; zmode 0/1 forces Zero, 2 randomizes it every cycle.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] fn3,
                           input logic fb, input int zmode);
    make_plan(o, fn3);
    foreach (plan_q[k]) begin
      @(posedge clk);
      #2;
      if (k == 0) begin op = o; f3 = fn3; f7 = fb; end
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      chk(tag, 0, exp_vec(plan_q[k], op, f3, f7, zero));
      chk(tag, 1, exp_vec(plan_q[k], op, f3, f7, zero));
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
    #1;
    chk(tag, 0, exp_vec(0, op, f3, f7, zero));
    chk(tag, 1, exp_vec(0, op, f3, f7, zero));
    repeat (2) @(posedge clk);
    #3;
    chk(tag, 0, exp_vec(0, op, f3, f7, zero));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] legal_f3 [4];
    logic [6:0] cls_op [6];
    logic [6:0] ro;
    logic [2:0] rf;
    legal_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};
    cls_op   = '{LW, SW, RT, IT, JAL, BEQ};
    rst_n = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
    #2;
    do_reset("reset");

    run_instr("add",   RT, 3'b000, 1'b0, 2);
    run_instr("sub",   RT, 3'b000, 1'b1, 2);
    run_instr("slti",  IT, 3'b010, 1'b0, 2);
    run_instr("addi7", IT, 3'b000, 1'b1, 2);
    run_instr("lw",    LW, 3'b010, 1'b0, 2);
    run_instr("sw",    SW, 3'b010, 1'b0, 2);
    run_instr("beq_z1", BEQ, 3'b000, 1'b0, 1);
    run_instr("beq_z0", BEQ, 3'b000, 1'b0, 0);
    run_instr("jal",   JAL, 3'b101, 1'b1, 2);
    run_instr("or",    RT, 3'b110, 1'b0, 2);
    run_instr("andi",  IT, 3'b111, 1'b1, 2);

    for (int n = 0; n < 60; n++) begin
      ro = cls_op[$urandom_range(0, 5)];
      rf = ((ro == RT) || (ro == IT)) ? legal_f3[$urandom_range(0, 3)] : 3'($urandom);
      run_instr("rand", ro, rf, 1'($urandom), 2);
    end

    // Illegal opcode: halting instance sticks, the other refetches.
    run_instr("ill_op", 7'b1111111, 3'b000, 1'b0, 2);
    make_plan(op, f3);
    foreach (plan_q[k]) begin
      @(posedge clk);
      #3;
      chk("ill_hold", 0, exp_vec(12, op, f3, f7, zero));
      chk("ill_refetch", 1, exp_vec(plan_q[k], op, f3, f7, zero));
    end

    do_reset("reset2");
    run_instr("ill_f3", RT, 3'b001, 1'b0, 2);
    do_reset("reset3");
    run_instr("ill_if3", IT, 3'b100, 1'b0, 2);
    do_reset("reset4");

    // Reset pulse while the store strobe is high must drop it at once.
    run_instr("sw_abort", SW, 3'b010, 1'b0, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort", 0, exp_vec(0, op, f3, f7, zero));
    chk("abort", 1, exp_vec(0, op, f3, f7, zero));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("post_abort", LW, 3'b010, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
